// File: rtl/index_reg_bank_if.sv
// Bus bundle for index_reg_bank: per-channel controls, shared write/compare data,
// and the registered read port with its status flags.
interface index_reg_bank_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
);
    logic [NCH-1:0]   CLR;
    logic [NCH-1:0]   WR;
    logic [NCH-1:0]   INC;
    logic [NCH-1:0]   DEC;
    logic [WIDTH-1:0] BIN;
    logic             LDBUS;
    logic [SELW-1:0]  BUS_SEL;
    logic [WIDTH-1:0] LIMIT;
    logic [WIDTH-1:0] BOUT;
    logic             BVALID;
    logic [NCH-1:0]   AT_LIM;
    logic [NCH-1:0]   OVF;

    modport master (
        output CLR, WR, INC, DEC, BIN, LDBUS, BUS_SEL, LIMIT,
        input  BOUT, BVALID, AT_LIM, OVF
    );

    modport slave (
        input  CLR, WR, INC, DEC, BIN, LDBUS, BUS_SEL, LIMIT,
        output BOUT, BVALID, AT_LIM, OVF
    );
endinterface

// File: rtl/index_reg_bank.sv
// Bank of NCH independent counter registers with clear/write/inc/dec, wrap or
// saturate arithmetic, limit compare, sticky overflow and a registered read port.
module index_reg_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NCH      = 4,
    parameter int unsigned SELW     = 2,
    parameter int unsigned STEP     = 1,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic            clk,
    input  logic            RST,
    index_reg_bank_if.slave bus
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic [WIDTH-1:0] bout_q;
    logic [WIDTH-1:0] bout_d;
    logic             bvalid_q;
    logic             bvalid_d;
    logic [WIDTH-1:0] rd_data;
    logic [NCH-1:0]   at_lim;

    // Sum and difference carry one extra bit so the top bit flags overflow/borrow.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        sum  = '0;
        diff = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            sum      = {1'b0, cnt_q[i]} + STEP_X;
            diff     = {1'b0, cnt_q[i]} - STEP_X;
            if (bus.CLR[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (bus.WR[i]) begin
                cnt_d[i] = bus.BIN;
            end else if (bus.INC[i] && !bus.DEC[i]) begin
                cnt_d[i] = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d[i] = 1'b1;
                    if (SAT_MODE) begin
                        cnt_d[i] = '1;
                    end
                end
            end else if (bus.DEC[i] && !bus.INC[i]) begin
                cnt_d[i] = diff[WIDTH-1:0];
                if (diff[WIDTH]) begin
                    ovf_d[i] = 1'b1;
                    if (SAT_MODE) begin
                        cnt_d[i] = '0;
                    end
                end
            end
        end
    end

    // Unmatched selects (BUS_SEL >= NCH) fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.BUS_SEL == SELW'(i)) begin
                rd_data = cnt_q[i];
            end
        end
    end

    always_comb begin
        bout_d   = bout_q;
        bvalid_d = 1'b0;
        if (bus.LDBUS) begin
            bout_d   = rd_data;
            bvalid_d = 1'b1;
        end
    end

    always_comb begin
        at_lim = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            at_lim[i] = (cnt_q[i] == bus.LIMIT);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q    <= '0;
            bout_q   <= '0;
            bvalid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q    <= ovf_d;
            bout_q   <= bout_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign bus.BOUT   = bout_q;
    assign bus.BVALID = bvalid_q;
    assign bus.AT_LIM = at_lim;
    assign bus.OVF    = ovf_q;

endmodule
